secuenciador_mac: RTL

SECUENCIADOR_MAC -- requirements
Module: secuenciador_mac

---
 rtl/filtro_pkg.sv | 15 +
 rtl/secuenciador_mac_if.sv | 24 ++
 rtl/contador_taps.sv | 32 +++
 rtl/secuenciador_mac.sv | 111 +++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - shared state encoding and size defaults for the MAC filter sequencer
package filtro_pkg;

  localparam int TAPS_DEF = 5;
  localparam int AW_DEF   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

endpackage

// File: rtl/secuenciador_mac_if.sv
// rtl/secuenciador_mac_if.sv - control bundle between the sequencer (master) and the MAC datapath (slave)
interface secuenciador_mac_if import filtro_pkg::*; #(parameter int AW = AW_DEF);

  logic          start;
  logic [AW-1:0] addr;
  logic          hold_mult;
  logic          hold_suma;
  logic          clr_acc;
  logic          hold_salida;
  logic          busy;
  logic          done;
  logic          overrun;

  modport master (
    input  start,
    output addr, hold_mult, hold_suma, clr_acc, hold_salida, busy, done, overrun
  );

  modport slave (
    output start,
    input  addr, hold_mult, hold_suma, clr_acc, hold_salida, busy, done, overrun
  );

endinterface

// File: rtl/contador_taps.sv
// rtl/contador_taps.sv - saturating tap address counter with clear, enable and terminal count
module contador_taps import filtro_pkg::*; #(
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_q,
  output logic          o_tc
);

  localparam logic [AW-1:0] LP_ULT = AW'(TAPS - 1);

  logic [AW-1:0] r_q;

  // Saturates at the last tap so the address can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != LP_ULT)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q  = r_q;
  assign o_tc = (r_q == LP_ULT);

endmodule

// File: rtl/secuenciador_mac.sv
// rtl/secuenciador_mac.sv - FIR multiply-accumulate control sequencer; SECUENCIADOR_OVERRUN_EN enables the sticky overrun flag
module secuenciador_mac import filtro_pkg::*; #(
  parameter int TAPS = TAPS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  secuenciador_mac_if.master    bus
);

  estado_t       r_estado;
  estado_t       w_sig;
  logic          r_ultimo;
  logic          w_clr_cnt;
  logic          w_en_cnt;
  logic          w_tc;
  logic [AW-1:0] w_addr;

  contador_taps #(.TAPS(TAPS), .AW(AW)) u_contador (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr_cnt),
    .i_en  (w_en_cnt),
    .o_q   (w_addr),
    .o_tc  (w_tc)
  );

  assign bus.addr = w_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= ST_IDLE;
    end else begin
      r_estado <= w_sig;
    end
  end

  // MAC keeps one extra cycle after the last address so the final product is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ultimo <= 1'b0;
    end else begin
      r_ultimo <= (r_estado == ST_MAC) && w_tc && !r_ultimo;
    end
  end

  always_comb begin
    w_sig           = r_estado;
    w_clr_cnt       = 1'b0;
    w_en_cnt        = 1'b0;
    bus.hold_mult   = 1'b1;
    bus.hold_suma   = 1'b1;
    bus.clr_acc     = 1'b0;
    bus.hold_salida = 1'b1;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    case (r_estado)
      ST_IDLE: begin
        bus.busy  = 1'b0;
        w_clr_cnt = 1'b1;
        if (bus.start) begin
          w_sig = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        bus.clr_acc   = 1'b1;
        bus.hold_mult = 1'b0;
        w_en_cnt      = 1'b1;
        w_sig         = ST_MAC;
      end
      ST_MAC: begin
        bus.hold_mult = 1'b0;
        bus.hold_suma = 1'b0;
        w_en_cnt      = 1'b1;
        if (r_ultimo) begin
          w_sig = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        bus.hold_suma = 1'b0;
        w_sig         = ST_DONE;
      end
      ST_DONE: begin
        bus.hold_salida = 1'b0;
        bus.done        = 1'b1;
        w_clr_cnt       = 1'b1;
        w_sig           = ST_IDLE;
      end
      default: begin
        w_sig = ST_IDLE;
      end
    endcase
  end

`ifdef SECUENCIADOR_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (bus.start && (r_estado != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.overrun = r_overrun;
`else
  assign bus.overrun = 1'b0;
`endif

endmodule
